// File: rtl/bitlogic_arbiter.sv
// bitlogic_arbiter
//   Round-robin arbiter that shares one n-bit bitwise logic stage
//   (NAND/AND/OR/XOR) between two requesters, A and B.
//   Each accepted operation walks IDLE -> EXEC -> DONE.
//   The winner's opcode and operands are captured at the grant edge.
//   The result is computed from those captured values in EXEC.
//   It is visible from DONE onward and holds until the next DONE.
//
//   Optional feature: define BITLOGIC_OPCNT_EN to add op_count[15:0].
//   op_count is a saturating count of completed operations.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous reset, active high
//   req_a/req_b    level requests, held by each requester until its done
//   op_a/op_b      opcode: 00 NAND, 01 AND, 10 OR, 11 XOR
//   x_a,y_a/x_b,y_b  operands, n bits each
//   gnt_a/gnt_b    owner of the unit, high in EXEC and DONE
//   done_a/done_b  one-cycle pulse in DONE; result valid for that owner
//   result         registered result
//   busy           state is not IDLE
//   op_count       (BITLOGIC_OPCNT_EN only) completed-operation count
//
// State table
//   state | meaning
//   IDLE  | sample requests; grant the winner and capture its operands
//   EXEC  | compute result from the captured operands; requests ignored
//   DONE  | pulse done to the owner; hand priority to the other side

module bitlogic_arbiter #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_a,
  input  logic [1:0]   op_a,
  input  logic [n-1:0] x_a,
  input  logic [n-1:0] y_a,
  input  logic         req_b,
  input  logic [1:0]   op_b,
  input  logic [n-1:0] x_b,
  input  logic [n-1:0] y_b,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         done_a,
  output logic         done_b,
  output logic [n-1:0] result,
  output logic         busy
`ifdef BITLOGIC_OPCNT_EN
  ,
  output logic [15:0]  op_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // owner/priority encoding: 0 = requester A, 1 = requester B
  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

  state_t         state, state_nxt;
  logic           owner, owner_nxt;
  logic           prio, prio_nxt;
  logic           sel_b;
  logic           cap_en;
  logic [1:0]     op_q;
  logic [n-1:0]   x_q;
  logic [n-1:0]   y_q;
  logic [1:0]     cap_op;
  logic [n-1:0]   cap_x;
  logic [n-1:0]   cap_y;
  logic [n-1:0]   result_q;

  function automatic logic [n-1:0] logic_fn(
    input logic [1:0]   op,
    input logic [n-1:0] x,
    input logic [n-1:0] y
  );
    logic [n-1:0] r;
    case (op)
      2'b00:   r = ~(x & y);
      2'b01:   r = x & y;
      2'b10:   r = x | y;
      default: r = x ^ y;
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    prio_nxt  = prio;
    sel_b     = 1'b0;
    cap_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_a || req_b) begin
          // a lone requester always wins; a tie goes to the priority holder
          sel_b     = (req_a && req_b) ? (prio == SIDE_B) : req_b;
          owner_nxt = sel_b;
          cap_en    = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        prio_nxt  = ~owner;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cap_op = sel_b ? op_b : op_a;
  assign cap_x  = sel_b ? x_b  : x_a;
  assign cap_y  = sel_b ? y_b  : y_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= SIDE_A;
      prio     <= SIDE_A;
      op_q     <= 2'b00;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      prio  <= prio_nxt;
      if (cap_en) begin
        op_q <= cap_op;
        x_q  <= cap_x;
        y_q  <= cap_y;
      end
      if (state == ST_EXEC) begin
        result_q <= logic_fn(op_q, x_q, y_q);
      end
    end
  end

  // Grants and done pulses decode straight from registered state.
  // That makes them glitch-free, and they drop on the same edge as a reset.
  assign busy   = (state != ST_IDLE);
  assign gnt_a  = busy && (owner == SIDE_A);
  assign gnt_b  = busy && (owner == SIDE_B);
  assign done_a = (state == ST_DONE) && (owner == SIDE_A);
  assign done_b = (state == ST_DONE) && (owner == SIDE_B);
  assign result = result_q;

`ifdef BITLOGIC_OPCNT_EN
  logic [15:0] op_cnt_q;

  // Counted on the edge that leaves DONE.
  // An operation aborted by reset never gets there, so it is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt_q <= 16'd0;
    end else if ((state == ST_DONE) && (op_cnt_q != 16'hFFFF)) begin
      op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  assign op_count = op_cnt_q;
`endif

endmodule

// File: tb/tb_bitlogic_arbiter.sv
module tb_bitlogic_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         req_a, req_b;
  logic [1:0]   op_a, op_b;
  logic [N-1:0] x_a, y_a, x_b, y_b;
  logic         gnt_a, gnt_b, done_a, done_b, busy;
  logic [N-1:0] result;
`ifdef BITLOGIC_OPCNT_EN
  logic [15:0]  op_count;
`endif

  bitlogic_arbiter #(.n(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .req_a  (req_a),
    .op_a   (op_a),
    .x_a    (x_a),
    .y_a    (y_a),
    .req_b  (req_b),
    .op_b   (op_b),
    .x_b    (x_b),
    .y_b    (y_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .done_a (done_a),
    .done_b (done_b),
    .result (result),
    .busy   (busy)
`ifdef BITLOGIC_OPCNT_EN
    ,
    .op_count (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endtask

  function automatic logic [N-1:0] op_ref(input logic [1:0] op, input logic [N-1:0] x,
                                          input logic [N-1:0] y);
    logic [N-1:0] r;
    case (op)
      2'b00:   r = ~(x & y);
      2'b01:   r = x & y;
      2'b10:   r = x | y;
      default: r = x ^ y;
    endcase
    return r;
  endfunction

  // Transaction-level reference model.
  // m_left is the number of owned cycles still to come: 2 means the grant
  // cycle, 1 means the done cycle, 0 means free.
  // The result is computed at grant time from the operands then presented.
  int           m_left = 0;
  bit           m_who  = 1'b0;   // 1 = B
  bit           m_prio = 1'b0;   // 1 = B
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_res  = '0;
`ifdef BITLOGIC_OPCNT_EN
  logic [15:0]  m_cnt  = 16'd0;
`endif

  always begin
    @(posedge clk);
    if (rst) begin
      m_left = 0;
      m_prio = 1'b0;
      m_res  = '0;
`ifdef BITLOGIC_OPCNT_EN
      m_cnt  = 16'd0;
`endif
    end else if (m_left == 2) begin
      m_left = 1;
      m_res  = m_pend;
    end else if (m_left == 1) begin
      m_left = 0;
      m_prio = !m_who;
`ifdef BITLOGIC_OPCNT_EN
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
    end else if (req_a || req_b) begin
      m_who  = (req_a && req_b) ? m_prio : req_b;
      m_pend = m_who ? op_ref(op_b, x_b, y_b) : op_ref(op_a, x_a, y_a);
      m_left = 2;
    end
  end

  always begin
    @(negedge clk);
    if (chk_en) begin
      check("model_outputs",
            16'({gnt_a, gnt_b, done_a, done_b, busy, result}),
            16'({(m_left != 0) && !m_who, (m_left != 0) && m_who,
                 (m_left == 1) && !m_who, (m_left == 1) && m_who,
                 m_left != 0, m_res}));
`ifdef BITLOGIC_OPCNT_EN
      check("model_op_count", op_count, m_cnt);
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  logic [N-1:0] sweep_exp [4];

  initial begin
    sweep_exp[0] = 4'b1101;
    sweep_exp[1] = 4'b0010;
    sweep_exp[2] = 4'b0111;
    sweep_exp[3] = 4'b0101;

    rst = 1'b1;
    req_a = 1'b0; op_a = 2'b00; x_a = '0; y_a = '0;
    req_b = 1'b0; op_b = 2'b00; x_b = '0; y_b = '0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    tick();
    check("reset_outputs", 16'({gnt_a, gnt_b, done_a, done_b, busy, result}), 16'd0);
    rst = 1'b0;

    // single A NAND request
    req_a = 1'b1; op_a = 2'b00; x_a = 4'b1100; y_a = 4'b1010;
    tick();
    check("s1_grant", 16'({gnt_a, gnt_b, done_a, busy}), 16'b1001);
    tick();
    check("s1_done", 16'({done_a, done_b, gnt_a, result}), 16'({3'b101, 4'b0111}));
    req_a = 1'b0;
    tick();
    check("s1_idle_hold", 16'({busy, gnt_a, result}), 16'({2'b00, 4'b0111}));

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // both requesters continuously pending: A, B, A
    req_a = 1'b1; op_a = 2'b01; x_a = 4'hF; y_a = 4'h5;
    req_b = 1'b1; op_b = 2'b11; x_b = 4'hF; y_b = 4'h5;
    for (int i = 1; i <= 8; i++) begin
      tick();
      case (i)
        1: check("s2_gnt1", 16'({gnt_a, gnt_b}), 16'b10);
        2: check("s2_done1", 16'({done_a, done_b, result}), 16'({2'b10, 4'h5}));
        4: check("s2_gnt2", 16'({gnt_a, gnt_b}), 16'b01);
        5: check("s2_done2", 16'({done_a, done_b, result}), 16'({2'b01, 4'hA}));
        7: check("s2_gnt3", 16'({gnt_a, gnt_b}), 16'b10);
        8: check("s2_done3", 16'({done_a, done_b, result}), 16'({2'b10, 4'h5}));
        default: ;
      endcase
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();

    // opcode sweep on requester A
    for (int k = 0; k < 4; k++) begin
      req_a = 1'b1; op_a = 2'(k); x_a = 4'b0110; y_a = 4'b0011;
      tick();
      tick();
      check("s3_sweep", 16'({done_a, result}), 16'({1'b1, sweep_exp[k]}));
      req_a = 1'b0;
      tick();
    end

    // operand change after the grant must not reach the result
    req_a = 1'b1; op_a = 2'b01; x_a = 4'hF; y_a = 4'hF;
    tick();
    x_a = 4'h0;
    tick();
    check("s4_captured", 16'({done_a, result}), 16'({1'b1, 4'hF}));
    req_a = 1'b0;
    tick();

    // reset while B is in EXEC; priority had moved to B and must return to A
    req_b = 1'b1; op_b = 2'b10; x_b = 4'h3; y_b = 4'h5;
    tick();
    check("s5_gnt_b", 16'({gnt_a, gnt_b, busy}), 16'b011);
    rst = 1'b1; req_b = 1'b0;
    tick();
    check("s5_abort", 16'({gnt_a, gnt_b, done_a, done_b, busy, result}), 16'd0);
    rst = 1'b0;
    req_a = 1'b1; op_a = 2'b11; x_a = 4'h9; y_a = 4'h3;
    req_b = 1'b1; op_b = 2'b01; x_b = 4'hF; y_b = 4'hF;
    tick();
    check("s5_a_first", 16'({gnt_a, gnt_b}), 16'b10);
    tick();
    check("s5_a_done", 16'({done_a, done_b, result}), 16'({2'b10, 4'hA}));
    req_a = 1'b0; req_b = 1'b0;
    tick();

`ifdef BITLOGIC_OPCNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_a = 1'b1; op_a = 2'b10; x_a = 4'h1; y_a = 4'h2;
      tick();
      tick();
      req_a = 1'b0;
      tick();
    end
    check("opcnt_three", op_count, 16'd3);
    @(posedge clk);
    #1 force dut.op_cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(posedge clk);
    #1 release dut.op_cnt_q;
    req_b = 1'b1; op_b = 2'b01; x_b = 4'h7; y_b = 4'h3;
    tick();
    tick();
    req_b = 1'b0;
    tick();
    check("opcnt_saturate", op_count, 16'hFFFF);
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bitlogic_arbiter.md
Name: bitlogic_arbiter

Overview:
- Shares one n-bit bitwise logic unit (NAND/AND/OR/XOR) between two requesters, A and B.
- Uses a req/grant/done handshake and round-robin priority.
- Each accepted operation runs through a 3-state FSM; the operands and the result are registered.
- Sits between lab datapath clients and a single shared bitwise logic stage.

Parameters:
- n, 4, operand/result width in bits (n ≥ 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req_a  input  1  requester A operation request (level).
- op_a  input  2  requester A opcode.
- x_a  input  n  requester A operand 1.
- y_a  input  n  requester A operand 2.
- req_b  input  1  requester B operation request (level).
- op_b  input  2  requester B opcode.
- x_b  input  n  requester B operand 1.
- y_b  input  n  requester B operand 2.
- gnt_a  output  1  A owns the unit (EXEC and DONE states).
- gnt_b  output  1  B owns the unit (EXEC and DONE states).
- done_a  output  1  one-cycle pulse; result valid for A.
- done_b  output  1  one-cycle pulse; result valid for B.
- result  output  n  registered result; holds its value until the next DONE.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Single clock domain; rst is synchronous and active-high (clk, rst).
- Opcodes:
  - 00: NAND, ~(x&y)
  - 01: AND, x&y
  - 10: OR, x|y
  - 11: XOR, x^y
  - Applied bitwise over all n bits; no carries; result width is exactly n.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - Samples req_a/req_b.
  - If exactly one is high, that requester is granted.
  - If both are high, the priority holder is granted.
  - On grant: latch op, x and y of the winner; set gnt_<w>; next state EXEC.
  - If neither is high, stay in IDLE.
- EXEC:
  - result <= f(op_latched, x_latched, y_latched); next state DONE.
  - Requests are ignored.
- DONE:
  - done_<w>=1 for exactly this cycle; gnt_<w> stays high.
  - Priority pointer moves to the other requester; next state IDLE unconditionally.
  - Requests are not sampled.
- Latency: req seen high in IDLE at edge k → gnt at k+1 → done and result at k+2 (valid during cycle k+2 → k+3).
  - Throughput: one operation every 3 cycles when requests are continuous.
- Operands are captured only at the grant edge. Changes to x/y/op after the grant do not affect the in-flight result.
- Handshake:
  - Requester holds req until it sees done.
  - If req is still high in the following IDLE cycle, it is treated as a new request. Both requesters always pending therefore alternate A, B, A, ...
- Reset values:
  - state = IDLE; priority = A.
  - gnt_a = gnt_b = done_a = done_b = busy = 0; result = 0.
- Reset mid-operation (EXEC or DONE): the in-flight operation is discarded.
  - No done is issued; all outputs return to reset values on that edge.
  - Priority returns to A.
- Never more than one of gnt_a/gnt_b is high; never more than one of done_a/done_b is high.
- A request that drops before it is granted is simply not served; there is no queuing.

Optional Feature:
- Macro: BITLOGIC_OPCNT_EN.
- Defined:
  - Adds output port op_count [15:0].
  - It increments by 1 on each DONE cycle, i.e. per completed operation from either requester.
  - Saturates at 16'hFFFF; reset value 0; also cleared by rst mid-operation.
  - An operation aborted by reset is not counted.
- Undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then req_a=1, op_a=00, x_a=4'b1100, y_a=4'b1010:
  - gnt_a=1 at the next edge.
  - done_a=1 with result=4'b0111 two edges after the request.
  - busy high for 2 cycles; gnt_b and done_b stay 0.
- Both requests held high, A: op=01 x=F y=5; B: op=11 x=F y=5:
  - Grants in order A, B, A.
  - Results: A gets 4'h5, B gets 4'hA, A gets 4'h5.
  - A done pulse every 3 cycles, alternating done_a and done_b.
- Opcode sweep, x=4'b0110, y=4'b0011, ops 00/01/10/11:
  - Results in order: 4'b1101, 4'b0010, 4'b0111, 4'b0101.
- Operand change after grant: x_a changes from 4'hF to 4'h0 in the EXEC cycle with op=01, y=4'hF:
  - result=4'hF (the captured value is used).
- rst asserted during EXEC of a B operation:
  - No done_b; all outputs 0 next cycle; result=0.
  - A following simultaneous A+B request grants A first.
- With BITLOGIC_OPCNT_EN: 3 completed operations → op_count=3.
  - Preloading the counter to 16'hFFFF and completing one more operation → stays 16'hFFFF.
